// File: rtl/interrupt_responder.sv
// -----------------------------------------------------------------------------
// interrupt_responder
//
// Purpose:
//   CPU-side consumer of the NMI edge latch and the level IRQ line. At an
//   instruction boundary it decides whether to take an interrupt, then runs the
//   7-cycle 6502 entry sequence: two dummy reads at PC, push PCH/PCL/P on the
//   stack page, and fetch the vector low/high bytes. A final DONE cycle hands
//   the new PC and stack pointer back to the core. A taken NMI is acknowledged
//   to the edge latch with a single nmi_clear pulse during the vector-low read.
//
// Configuration:
//   INTR_NMI_HIJACK_EN  when defined, an NMI that becomes pending while an IRQ
//                       sequence is still in DUM1..PSTAT converts the sequence
//                       into an NMI entry (NMI vector, nmi_clear pulsed). The
//                       pushed PC/P are unaffected. When undefined, the source
//                       is fixed at the instruction boundary and a late NMI
//                       stays pending for the next boundary.
//
// Ports:
//   clk          in   1   CPU clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   nmi_pending  in   1   latched NMI request
//   irq_n        in   1   IRQ line, level, active-low
//   i_flag       in   1   CPU I flag (masks IRQ only)
//   instr_done   in   1   instruction boundary pulse
//   ready        in   1   bus ready; 0 freezes the sequence
//   pc_in        in  16   PC to push
//   p_in         in   8   status register to push
//   sp_in        in   8   stack pointer at sequence start
//   bus_rdata    in   8   read data for the address driven this cycle
//   bus_addr     out 16   bus address
//   bus_wdata    out  8   bus write data
//   bus_we       out  1   write strobe
//   busy         out  1   sequence active
//   nmi_clear    out  1   ack to the NMI edge latch
//   pc_load      out  1   load new_pc / sp_out into the core, set I
//   new_pc       out 16   vector fetched from memory
//   sp_out       out  8   sp_in - 3 (mod 256)
// -----------------------------------------------------------------------------
module interrupt_responder #(
  parameter logic [15:0] NMI_VEC  = 16'hFFFA,
  parameter logic [15:0] IRQ_VEC  = 16'hFFFE,
  parameter logic [7:0]  STACK_PG = 8'h01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        nmi_pending,
  input  logic        irq_n,
  input  logic        i_flag,
  input  logic        instr_done,
  input  logic        ready,
  input  logic [15:0] pc_in,
  input  logic [7:0]  p_in,
  input  logic [7:0]  sp_in,
  input  logic [7:0]  bus_rdata,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  output logic        bus_we,
  output logic        busy,
  output logic        nmi_clear,
  output logic        pc_load,
  output logic [15:0] new_pc,
  output logic [7:0]  sp_out
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_DUM1,
    S_DUM2,
    S_PCH,
    S_PCL,
    S_PSTAT,
    S_VLO,
    S_VHI,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_src_nmi;
  logic        w_src_nmi_next;
  logic [15:0] r_pc;
  logic [7:0]  r_p;
  logic [7:0]  r_sp;
  logic [15:0] r_new_pc;
  logic [7:0]  r_sp_out;

  logic        w_take;
  logic        w_start;
  logic [15:0] w_vec;
  logic [15:0] w_vec_hi;
  logic [7:0]  w_sp_m1;
  logic [7:0]  w_sp_m2;
  logic [7:0]  w_sp_m3;
  logic [7:0]  w_p_push;

  // NMI is never masked; IRQ is masked by the I flag.
  assign w_take   = nmi_pending | (~irq_n & ~i_flag);
  assign w_start  = (r_state == S_IDLE) & instr_done & w_take;

  assign w_vec    = r_src_nmi ? NMI_VEC : IRQ_VEC;
  assign w_vec_hi = w_vec + 16'd1;

  // Stack offsets wrap within the stack page.
  assign w_sp_m1  = r_sp - 8'd1;
  assign w_sp_m2  = r_sp - 8'd2;
  assign w_sp_m3  = r_sp - 8'd3;

  // Pushed P has B (bit 4) cleared and bit 5 set, as for a hardware interrupt.
  assign w_p_push = {r_p[7:6], 1'b1, 1'b0, r_p[3:0]};

  assign new_pc   = r_new_pc;
  assign sp_out   = r_sp_out;

  always_comb begin
    w_state_next   = r_state;
    w_src_nmi_next = r_src_nmi;
    bus_addr       = 16'h0000;
    bus_wdata      = 8'h00;
    bus_we         = 1'b0;
    busy           = 1'b1;
    nmi_clear      = 1'b0;
    pc_load        = 1'b0;

    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        // Boundary decisions are not gated by ready so a one-cycle
        // instr_done pulse is never lost.
        if (w_start) begin
          w_state_next   = S_DUM1;
          w_src_nmi_next = nmi_pending;
        end
      end
      S_DUM1: begin
        bus_addr = r_pc;
        if (ready) w_state_next = S_DUM2;
      end
      S_DUM2: begin
        bus_addr = r_pc;
        if (ready) w_state_next = S_PCH;
      end
      S_PCH: begin
        bus_addr  = {STACK_PG, r_sp};
        bus_wdata = r_pc[15:8];
        bus_we    = 1'b1;
        if (ready) w_state_next = S_PCL;
      end
      S_PCL: begin
        bus_addr  = {STACK_PG, w_sp_m1};
        bus_wdata = r_pc[7:0];
        bus_we    = 1'b1;
        if (ready) w_state_next = S_PSTAT;
      end
      S_PSTAT: begin
        bus_addr  = {STACK_PG, w_sp_m2};
        bus_wdata = w_p_push;
        bus_we    = 1'b1;
        if (ready) w_state_next = S_VLO;
      end
      S_VLO: begin
        bus_addr  = w_vec;
        // Held through a stall; the latch sees it as one acknowledge.
        nmi_clear = r_src_nmi;
        if (ready) w_state_next = S_VHI;
      end
      S_VHI: begin
        bus_addr = w_vec_hi;
        if (ready) w_state_next = S_DONE;
      end
      S_DONE: begin
        pc_load = 1'b1;
        if (ready) w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

`ifdef INTR_NMI_HIJACK_EN
    // A late NMI can still redirect the vector fetch as long as it is seen
    // before the sequence leaves PSTAT.
    if (nmi_pending && (r_state == S_DUM1 || r_state == S_DUM2 ||
                        r_state == S_PCH  || r_state == S_PCL  ||
                        r_state == S_PSTAT)) begin
      w_src_nmi_next = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_src_nmi <= 1'b0;
      r_pc      <= 16'h0000;
      r_p       <= 8'h00;
      r_sp      <= 8'h00;
      r_new_pc  <= 16'h0000;
      r_sp_out  <= 8'h00;
    end else begin
      r_state   <= w_state_next;
      r_src_nmi <= w_src_nmi_next;
      if (w_start) begin
        r_pc <= pc_in;
        r_p  <= p_in;
        r_sp <= sp_in;
      end
      // Vector bytes are only valid on a cycle the bus completes.
      if (r_state == S_VLO && ready) begin
        r_new_pc[7:0] <= bus_rdata;
      end
      if (r_state == S_VHI && ready) begin
        r_new_pc[15:8] <= bus_rdata;
        r_sp_out       <= w_sp_m3;
      end
    end
  end

endmodule

// File: tb/tb_interrupt_responder.sv
module tb_interrupt_responder;

  logic        clk;
  logic        rst_n;
  logic        nmi_pending;
  logic        irq_n;
  logic        i_flag;
  logic        instr_done;
  logic        ready;
  logic [15:0] pc_in;
  logic [7:0]  p_in;
  logic [7:0]  sp_in;
  logic [7:0]  bus_rdata;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_we;
  logic        busy;
  logic        nmi_clear;
  logic        pc_load;
  logic [15:0] new_pc;
  logic [7:0]  sp_out;

  interrupt_responder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .nmi_pending(nmi_pending),
    .irq_n      (irq_n),
    .i_flag     (i_flag),
    .instr_done (instr_done),
    .ready      (ready),
    .pc_in      (pc_in),
    .p_in       (p_in),
    .sp_in      (sp_in),
    .bus_rdata  (bus_rdata),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_we     (bus_we),
    .busy       (busy),
    .nmi_clear  (nmi_clear),
    .pc_load    (pc_load),
    .new_pc     (new_pc),
    .sp_out     (sp_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector memory seen by the responder.
  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    case (a)
      16'hFFFA: return 8'h00;
      16'hFFFB: return 8'h80;
      16'hFFFE: return 8'h55;
      16'hFFFF: return 8'h66;
      default:  return 8'hEE;
    endcase
  endfunction

  assign bus_rdata = mem_rd(bus_addr);

`ifdef INTR_NMI_HIJACK_EN
  localparam logic HIJACK = 1'b1;
`else
  localparam logic HIJACK = 1'b0;
`endif

  // One expected bus cycle of the entry sequence.
  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wdata;
    logic        nclr;
    logic        pload;
    logic        chk_addr;
    logic        chk_pc;
    logic [15:0] npc;
    logic [7:0]  spo;
  } item_t;

  // One table-driven interrupt scenario.
  typedef struct {
    string       name;
    logic [15:0] pc;
    logic [7:0]  p;
    logic [7:0]  sp;
    logic        nmi;
    logic        irqn;
    logic        iflag;
    logic        take;
    logic        exp_nmi;
    int          stall_at;
    int          stall_len;
    int          nmi_at;
  } vec_t;

  item_t exp_q[$];
  int    n_pass = 0;
  int    n_total = 0;
  int    cyc = 0;
  int    first_load = -1;
  int    writes_seen = 0;
  int    clears_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endtask

  task automatic push(input logic [15:0] a, input logic we, input logic [7:0] wd,
                      input logic nc, input logic pl, input logic ca, input logic cp,
                      input logic [15:0] npc, input logic [7:0] spo);
    item_t it;
    it.addr = a; it.we = we; it.wdata = wd; it.nclr = nc; it.pload = pl;
    it.chk_addr = ca; it.chk_pc = cp; it.npc = npc; it.spo = spo;
    exp_q.push_back(it);
  endtask

  task automatic push_seq(input logic [15:0] pc, input logic [7:0] p, input logic [7:0] sp,
                          input logic is_nmi);
    logic [15:0] vec;
    logic [15:0] vec1;
    logic [7:0]  s1, s2, s3;
    vec  = is_nmi ? 16'hFFFA : 16'hFFFE;
    vec1 = vec + 16'd1;
    s1 = sp - 8'd1; s2 = sp - 8'd2; s3 = sp - 8'd3;
    push(pc, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 8'h0);
    push(pc, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 8'h0);
    push({8'h01, sp}, 1'b1, pc[15:8], 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 8'h0);
    push({8'h01, s1}, 1'b1, pc[7:0], 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 8'h0);
    push({8'h01, s2}, 1'b1, (p & 8'hEF) | 8'h20, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 8'h0);
    push(vec, 1'b0, 8'h00, is_nmi, 1'b0, 1'b1, 1'b0, 16'h0, 8'h0);
    push(vec1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 8'h0);
    push(16'h0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, {mem_rd(vec1), mem_rd(vec)}, s3);
  endtask

  // Advance one clock, sample 1 time unit after the edge, compare with the
  // scoreboard head. The head is retired only when the DUT advanced.
  task automatic tick();
    logic  adv;
    item_t e;
    adv = busy && ready;
    if (bus_we && ready) writes_seen++;
    if (nmi_clear && ready) clears_seen++;
    @(posedge clk);
    #1;
    cyc++;
    if (adv && exp_q.size() > 0) void'(exp_q.pop_front());
    if (pc_load && first_load < 0) first_load = cyc;
    if (busy) begin
      if (exp_q.size() == 0) begin
        check("unexpected_busy", busy, 1'b0);
      end else begin
        e = exp_q[0];
        check("bus_we", bus_we, e.we);
        if (e.chk_addr) check("bus_addr", bus_addr, e.addr);
        if (e.we) check("bus_wdata", bus_wdata, e.wdata);
        check("nmi_clear", nmi_clear, e.nclr);
        check("pc_load", pc_load, e.pload);
        if (e.chk_pc) begin
          check("new_pc", new_pc, e.npc);
          check("sp_out", sp_out, e.spo);
        end
      end
    end else begin
      check("idle_outputs", {bus_we, nmi_clear, pc_load}, 3'b000);
    end
  endtask

  task automatic run_seq(input vec_t v);
    int  start;
    int  w0, c0, idx, guard;
    bit  stalled;
    pc_in = v.pc; p_in = v.p; sp_in = v.sp;
    nmi_pending = v.nmi; irq_n = v.irqn; i_flag = v.iflag;
    ready = 1'b1;
    if (v.take) push_seq(v.pc, v.p, v.sp, v.exp_nmi);
    w0 = writes_seen; c0 = clears_seen;
    start = cyc; first_load = -1;
    instr_done = 1'b1;
    tick();
    instr_done = 1'b0;
    // Captured values must not follow the live inputs; IRQ level drop is ignored.
    pc_in = 16'h0BAD; p_in = 8'h5A; sp_in = 8'h77; irq_n = 1'b1;
    if (!v.take) begin
      repeat (3) tick();
      check({v.name, "_not_taken"}, busy, 1'b0);
    end else begin
      check({v.name, "_busy_T+1"}, busy, 1'b1);
      stalled = 0; guard = 0;
      while (exp_q.size() > 0 && guard < 40) begin
        guard++;
        idx = 8 - exp_q.size();
        if (v.nmi_at >= 0 && idx == v.nmi_at) nmi_pending = 1'b1;
        instr_done = (idx == 2);
        if (idx == v.stall_at && !stalled) begin
          ready = 1'b0;
          repeat (v.stall_len) tick();
          ready = 1'b1;
          stalled = 1;
        end else begin
          tick();
        end
      end
      instr_done = 1'b0;
      if (exp_q.size() > 0) begin
        check({v.name, "_timeout"}, exp_q.size(), 0);
        exp_q.delete();
      end
      check({v.name, "_busy_end"}, busy, 1'b0);
      check({v.name, "_latency"}, first_load - start, 8 + v.stall_len);
      check({v.name, "_writes"}, writes_seen - w0, 3);
      check({v.name, "_nmi_clears"}, clears_seen - c0, v.exp_nmi ? 1 : 0);
      if (v.exp_nmi) nmi_pending = 1'b0;
    end
    $display("seq %-10s pc=%h sp=%h take=%0d nmi=%0d load_at=T+%0d", v.name, v.pc, v.sp,
             v.take, v.exp_nmi, (first_load < 0) ? 0 : first_load - start);
  endtask

  vec_t tbl[9];

  initial begin
    tbl[0] = '{"nmi",     16'hC123, 8'h34, 8'hFD, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1,   -1, 0, -1};
    tbl[1] = '{"irq_mask",16'h2000, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,   -1, 0, -1};
    tbl[2] = '{"no_req",  16'h2000, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,   -1, 0, -1};
    tbl[3] = '{"irq",     16'h1234, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,   -1, 0, -1};
    tbl[4] = '{"prio_wrap",16'h4567,8'hC3, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1,   -1, 0, -1};
    tbl[5] = '{"irq_sp00",16'h89AB, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,   -1, 0, -1};
    tbl[6] = '{"stall",   16'hABCD, 8'h10, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,    3, 3, -1};
    tbl[7] = '{"hijack",  16'h1111, 8'h00, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, HIJACK, -1, 0,  1};
    tbl[8] = '{"nmi_next",16'h2222, 8'h00, 8'hE0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1,   -1, 0, -1};

    rst_n = 1'b0; nmi_pending = 1'b0; irq_n = 1'b1; i_flag = 1'b0;
    instr_done = 1'b0; ready = 1'b1; pc_in = 16'h0; p_in = 8'h0; sp_in = 8'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {bus_addr, bus_wdata, bus_we, busy, nmi_clear, pc_load, new_pc, sp_out}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) begin
      run_seq(tbl[i]);
      repeat (2) tick();
    end

    // Reset in the middle of a sequence, during PSTAT.
    pc_in = 16'h3456; p_in = 8'h00; sp_in = 8'hC0; nmi_pending = 1'b1;
    push_seq(16'h3456, 8'h00, 8'hC0, 1'b1);
    instr_done = 1'b1;
    tick();
    instr_done = 1'b0;
    repeat (4) tick();
    check("pre_reset_pstat", {bus_we, bus_addr}, {1'b1, 16'h01BE});
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_mid", {bus_addr, bus_wdata, bus_we, busy, nmi_clear, pc_load, new_pc, sp_out}, 0);
    exp_q.delete();
    nmi_pending = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    check("post_reset_idle", busy, 1'b0);
    $display("seq reset_mid pstat reset applied, idle after release");
    run_seq(tbl[2]);
    run_seq(tbl[0]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
